// File: rtl/mips_pkg.sv
// Shared constants for the instruction-fetch path: default word width, NOP encoding and legal read latencies.
package mips_pkg;

    localparam int          MIPS_DATA_W   = 32;
    localparam logic [31:0] MIPS_NOP_WORD = 32'h0000_0000;

    function automatic bit rd_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/instr_mem_param_if.sv
// Fetch, pipeline-control and program-load signals of the instruction memory; master drives requests, slave returns instructions.
interface instr_mem_param_if
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              fetch_en;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              addr_err;
    logic              prog_we;
    logic [IDX_W-1:0]  prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output fetch_en, stall, flush, pc, prog_we, prog_addr, prog_data,
        input  instr, instr_valid, addr_err
    );

    modport slave (
        input  fetch_en, stall, flush, pc, prog_we, prog_addr, prog_data,
        output instr, instr_valid, addr_err
    );

endinterface

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one registered read port (read-first), contents start at INIT_WORD.
module imem_ram
    import mips_pkg::*;
#(
    parameter int                DATA_W    = MIPS_DATA_W,
    parameter int                DEPTH     = 32,
    parameter logic [DATA_W-1:0] INIT_WORD = '0,
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

    // rdata only moves on re so a stalled pipeline keeps seeing the same word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem_param.sv
// Instruction fetch memory: pc decode, alignment/range check, write-first bypass, RD_LAT (1 or 2) output stages.
// One fetch per cycle; stall freezes every stage, flush empties them and wins over stall.
module instr_mem_param
    import mips_pkg::*;
#(
    parameter int                DATA_W   = MIPS_DATA_W,
    parameter int                DEPTH    = 32,
    parameter int                ADDR_W   = 32,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP_WORD)
) (
    input logic              clk,
    input logic              rst,
    instr_mem_param_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("instr_mem_param: RD_LAT must be 1 or 2");
    end

    logic              accept;
    logic              fetch_err;
    logic              wr_ok;
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] ram_rdata;

    logic              s1_vld;
    logic              s1_err;
    logic              s1_byp;
    logic [DATA_W-1:0] s1_byp_dat;
    logic [DATA_W-1:0] s1_dat;

    logic              out_vld;
    logic              out_err;
    logic [DATA_W-1:0] out_dat;

    assign wr_ok     = bus.prog_we & ~rst;
    assign accept    = bus.fetch_en & ~bus.stall & ~bus.flush;
    assign idx       = bus.pc[IDX_W+1:2];
    assign fetch_err = (bus.pc[1:0] != 2'b00) | ((bus.pc >> (IDX_W + 2)) != '0);
    assign hit       = wr_ok & (bus.prog_addr == idx);

    imem_ram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_WORD(NOP_WORD)
    ) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(bus.prog_addr),
        .wdata(bus.prog_data),
        .re   (accept),
        .raddr(idx),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_err     <= 1'b0;
            s1_byp     <= 1'b0;
            s1_byp_dat <= NOP_WORD;
        end else if (bus.flush) begin
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
            s1_byp <= 1'b0;
        end else if (!bus.stall) begin
            s1_vld <= bus.fetch_en;
            s1_err <= bus.fetch_en & fetch_err;
            s1_byp <= bus.fetch_en & hit;
            if (hit) s1_byp_dat <= bus.prog_data;
        end
    end

    // a same-cycle program write overrides the read-first RAM output
    assign s1_dat = (!s1_vld || s1_err) ? NOP_WORD : (s1_byp ? s1_byp_dat : ram_rdata);

    if (RD_LAT == 2) begin : g_two_stage
        logic              s2_vld;
        logic              s2_err;
        logic [DATA_W-1:0] s2_dat;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_vld <= 1'b0;
                s2_err <= 1'b0;
                s2_dat <= NOP_WORD;
            end else if (bus.flush) begin
                s2_vld <= 1'b0;
                s2_err <= 1'b0;
                s2_dat <= NOP_WORD;
            end else if (!bus.stall) begin
                s2_vld <= s1_vld;
                s2_err <= s1_err;
                s2_dat <= s1_dat;
            end
        end

        assign out_vld = s2_vld;
        assign out_err = s2_err;
        assign out_dat = s2_dat;
    end else begin : g_one_stage
        assign out_vld = s1_vld;
        assign out_err = s1_err;
        assign out_dat = s1_dat;
    end

    assign bus.instr       = out_dat;
    assign bus.instr_valid = out_vld;
    assign bus.addr_err    = out_err;

endmodule

// File: tb/tb_instr_mem_param.sv
// Drives one stimulus stream into an RD_LAT=1 and an RD_LAT=2 instance and scores both against a queue-based model.
module tb_instr_mem_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, stall, flush, prog_we;
    logic [31:0] pc, prog_data;
    logic [4:0]  prog_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_mem_param_if #(.DATA_W(32), .DEPTH(32), .ADDR_W(32)) bus1 ();
    instr_mem_param_if #(.DATA_W(32), .DEPTH(32), .ADDR_W(32)) bus2 ();

    assign bus1.fetch_en  = fetch_en;
    assign bus1.stall     = stall;
    assign bus1.flush     = flush;
    assign bus1.pc        = pc;
    assign bus1.prog_we   = prog_we;
    assign bus1.prog_addr = prog_addr;
    assign bus1.prog_data = prog_data;
    assign bus2.fetch_en  = fetch_en;
    assign bus2.stall     = stall;
    assign bus2.flush     = flush;
    assign bus2.pc        = pc;
    assign bus2.prog_we   = prog_we;
    assign bus2.prog_addr = prog_addr;
    assign bus2.prog_data = prog_data;

    instr_mem_param #(
        .DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(1), .NOP_WORD(32'h0000_0000)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    instr_mem_param #(
        .DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(2), .NOP_WORD(32'h0000_0000)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mem_m [32];
    logic [31:0] e1_dat, e2_dat;
    logic        e1_vld, e1_err, e2_vld, e2_err;
    int          adv    = 0;
    bit          mon_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_exp();
        q1.delete();
        q2.delete();
        e1_vld = 1'b0; e1_err = 1'b0; e1_dat = 32'h0;
        e2_vld = 1'b0; e2_err = 1'b0; e2_dat = 32'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [4:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        cyc();
        prog_we   = 1'b0;
    endtask

    // Scoreboard: accepted fetches are queued with the advancing-edge index at which they must appear.
    always @(posedge clk) begin : model
        exp_t e;
        if (rst || flush) begin
            clr_exp();
        end else if (!stall) begin
            adv++;
            if (fetch_en) begin
                e.err = (pc[1:0] != 2'b00) || (pc[31:7] != 25'h0);
                e.dat = e.err ? 32'h0 :
                        ((prog_we && prog_addr == pc[6:2]) ? prog_data : mem_m[pc[6:2]]);
                e.due = adv;
                q1.push_back(e);
                e.due = adv + 1;
                q2.push_back(e);
            end
            e1_vld = 1'b0; e1_err = 1'b0; e1_dat = 32'h0;
            e2_vld = 1'b0; e2_err = 1'b0; e2_dat = 32'h0;
            if (q1.size() > 0 && q1[0].due == adv) begin
                e = q1.pop_front();
                e1_vld = 1'b1; e1_err = e.err; e1_dat = e.dat;
            end
            if (q2.size() > 0 && q2[0].due == adv) begin
                e = q2.pop_front();
                e2_vld = 1'b1; e2_err = e.err; e2_dat = e.dat;
            end
        end
        if (prog_we && !rst) mem_m[prog_addr] = prog_data;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("l1_valid", 32'(bus1.instr_valid), 32'(e1_vld));
            check("l1_err",   32'(bus1.addr_err),    32'(e1_err));
            check("l1_instr", bus1.instr,            e1_dat);
            check("l2_valid", 32'(bus2.instr_valid), 32'(e2_vld));
            check("l2_err",   32'(bus2.addr_err),    32'(e2_err));
            check("l2_instr", bus2.instr,            e2_dat);
        end
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
        pc = 32'h0; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 32'h0;
        foreach (mem_m[i]) mem_m[i] = 32'h0;
        clr_exp();
        cyc();
        check("rst_instr1", bus1.instr, 32'h0);
        check("rst_valid1", 32'(bus1.instr_valid), 32'h0);
        check("rst_err1",   32'(bus1.addr_err), 32'h0);
        check("rst_valid2", 32'(bus2.instr_valid), 32'h0);
        cyc();
        rst    = 1'b0;
        mon_en = 1'b1;

        prog(5'd0, 32'h2410_0000);
        prog(5'd4, 32'h0800_000C);
        prog(5'd1, 32'h3C01_1234);
        prog(5'd5, 32'h1111_1111);

        // back-to-back program fetches
        fetch_en = 1'b1; pc = 32'd0; cyc();
        check("pl_w0", bus1.instr, 32'h2410_0000);
        check("pl_w0_vld", 32'(bus1.instr_valid), 32'h1);
        pc = 32'd16; cyc();
        check("pl_w4", bus1.instr, 32'h0800_000C);
        check("pl_w4_vld", 32'(bus1.instr_valid), 32'h1);
        fetch_en = 1'b0; cyc(); cyc();

        // three-cycle stall behind the pc=0 fetch
        fetch_en = 1'b1; pc = 32'd0; cyc();
        stall = 1'b1; pc = 32'd4;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_hold", bus1.instr, 32'h2410_0000);
            check("stall_hold_vld", 32'(bus1.instr_valid), 32'h1);
        end
        stall = 1'b0; cyc();
        check("stall_after", bus1.instr, 32'h3C01_1234);
        fetch_en = 1'b0; cyc(); cyc();

        // flush with fetches in flight; the fetch in the flush cycle is dropped
        fetch_en = 1'b1; pc = 32'd0; cyc();
        pc = 32'd16; cyc();
        flush = 1'b1; pc = 32'd4; cyc();
        check("flush_vld2_a",   32'(bus2.instr_valid), 32'h0);
        check("flush_instr2_a", bus2.instr, 32'h0);
        flush = 1'b0; fetch_en = 1'b0; cyc();
        check("flush_vld2_b",   32'(bus2.instr_valid), 32'h0);
        check("flush_instr2_b", bus2.instr, 32'h0);
        cyc();

        // misaligned and out-of-range pc
        fetch_en = 1'b1; pc = 32'd2; cyc();
        check("err_pc2_err", 32'(bus1.addr_err), 32'h1);
        check("err_pc2_vld", 32'(bus1.instr_valid), 32'h1);
        check("err_pc2_ins", bus1.instr, 32'h0);
        pc = 32'd128; cyc();
        check("err_pc128_err", 32'(bus1.addr_err), 32'h1);
        check("err_pc128_vld", 32'(bus1.instr_valid), 32'h1);
        check("err_pc2_err_l2", 32'(bus2.addr_err), 32'h1);
        fetch_en = 1'b0; cyc();
        check("err_pc128_err_l2", 32'(bus2.addr_err), 32'h1);
        check("err_pc128_ins_l2", bus2.instr, 32'h0);
        cyc();

        // write-first: program write and fetch hit word 5 together
        fetch_en = 1'b1; pc = 32'd20;
        prog_we = 1'b1; prog_addr = 5'd5; prog_data = 32'h8E08_0000; cyc();
        prog_we = 1'b0; fetch_en = 1'b0;
        check("wf_l1", bus1.instr, 32'h8E08_0000);
        cyc();
        check("wf_l2", bus2.instr, 32'h8E08_0000);
        cyc();

        // reset mid-stream: outputs drop immediately, memory survives, writes under reset ignored
        fetch_en = 1'b1; pc = 32'd16; cyc();
        pc = 32'd0; cyc();
        rst = 1'b1; fetch_en = 1'b0;
        clr_exp();
        #1;
        check("arst_instr1", bus1.instr, 32'h0);
        check("arst_vld1",   32'(bus1.instr_valid), 32'h0);
        check("arst_err1",   32'(bus1.addr_err), 32'h0);
        check("arst_instr2", bus2.instr, 32'h0);
        check("arst_vld2",   32'(bus2.instr_valid), 32'h0);
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 32'hDEAD_BEEF; cyc();
        prog_we = 1'b0; cyc();
        rst = 1'b0;
        fetch_en = 1'b1; pc = 32'd0; cyc();
        check("post_rst_w0", bus1.instr, 32'h2410_0000);
        pc = 32'd16; cyc();
        check("post_rst_w4", bus1.instr, 32'h0800_000C);
        fetch_en = 1'b0; cyc(); cyc();

        // random traffic scored by the monitor
        for (int i = 0; i < 80; i++) begin
            fetch_en  = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            pc        = ($urandom_range(0, 9) == 0) ? $urandom :
                        {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            prog_we   = ($urandom_range(0, 3) == 0);
            prog_addr = 5'($urandom_range(0, 31));
            prog_data = $urandom;
            cyc();
        end
        fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; prog_we = 1'b0;
        cyc(); cyc(); cyc();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_param.md
INSTR_MEM_PARAM -- requirements
Module: instr_mem_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of instruction words (power of two, 4..4096).
REQ-003 SHALL have parameter ADDR_W, default 32, width of the byte-addressed PC input.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles (legal values 1 or 2).
REQ-005 SHALL have parameter NOP_WORD, default 32'h00000000, the value driven whenever no valid instruction is presented.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port fetch_en, input, 1, request a fetch at pc this cycle.
REQ-009 SHALL have port stall, input, 1, hold all pipeline stages.
REQ-010 SHALL have port flush, input, 1, discard all in-flight fetches.
REQ-011 SHALL have port pc, input, ADDR_W, byte address of the requested instruction.
REQ-012 SHALL have port instr, output, DATA_W, fetched instruction.
REQ-013 SHALL have port instr_valid, output, 1, instr holds a valid fetch result.
REQ-014 SHALL have port addr_err, output, 1, the presented fetch had a misaligned or out-of-range pc.
REQ-015 SHALL have ports prog_we (input, 1), prog_addr (input, log2(DEPTH)) and prog_data (input, DATA_W), the word-indexed program-load write port.

Function
REQ-016 SHALL form word index = pc[log2(DEPTH)+1:2].
REQ-017 SHALL flag a fetch as erroneous when pc[1:0] != 0, or when any pc bit above log2(DEPTH)+1 is nonzero.
REQ-018 SHALL, for an erroneous fetch, deliver instr=NOP_WORD, instr_valid=1 and addr_err=1 with the same latency as a normal fetch.
REQ-019 SHALL accept a fetch when fetch_en=1, stall=0 and flush=0, and present its result exactly RD_LAT cycles later.
REQ-020 SHALL sustain one accepted fetch per cycle, returning results in acceptance order.
REQ-021 SHALL, when RD_LAT=2, add a second output register stage carrying instr, valid and err.
REQ-022 SHALL, while stall=1, hold every stage: instr, instr_valid and addr_err keep their values and no new fetch is accepted.
REQ-023 SHALL, when flush=1, clear valid in every stage at the next edge, drive instr=NOP_WORD and addr_err=0, and ignore fetch_en that cycle; flush takes priority over stall.
REQ-024 SHALL, for a cycle with fetch_en=0 and no stall, advance a bubble: instr_valid=0, instr=NOP_WORD.
REQ-025 SHALL write prog_data to word prog_addr at the clock edge when prog_we=1, regardless of stall or flush.
REQ-026 SHALL, when prog_we and an accepted fetch target the same index in the same cycle, return the new prog_data (write-first).
REQ-027 SHALL initialise all memory words to NOP_WORD at time zero; no contents are loaded from files inside the block.

Reset
REQ-028 SHALL, while rst=1, immediately force instr=NOP_WORD, instr_valid=0 and addr_err=0, clearing all stage registers.
REQ-029 SHALL discard any fetch in flight when rst asserts mid-operation; it is never presented.
REQ-030 SHALL leave memory contents unchanged across reset.
REQ-031 SHALL ignore prog_we while rst=1.

Structure
REQ-032 SHALL take NOP_WORD, default DATA_W and the RD_LAT legal-value check from the shared package mips_pkg.
REQ-033 SHALL place the storage array (one synchronous write port, one read port) in sub-module imem_ram.
REQ-034 SHALL keep pc decode, error detection, write-first bypass and stage registers in instr_mem_param.

Verification
REQ-035 SHALL cover program load: write 32'h24100000 to word 0 and 32'h0800000C to word 4, then fetch pc=0, pc=16 back-to-back with RD_LAT=1 -> instr=24100000, then 0800000C, on consecutive cycles with instr_valid=1.
REQ-036 SHALL cover stall: a stall pulse of 3 cycles after the pc=0 fetch -> instr=24100000 held for 3 cycles, and the pc=4 fetch appears only after stall drops.
REQ-037 SHALL cover flush with RD_LAT=2: two fetches in flight plus flush=1 -> instr_valid=0 and instr=NOP_WORD for the next 2 cycles.
REQ-038 SHALL cover error cases: pc=2 and pc=128 (DEPTH=32) -> addr_err=1, instr=00000000, instr_valid=1 after RD_LAT cycles.
REQ-039 SHALL cover write-first: prog_we to word 5 with 8E080000 in the same cycle as a fetch at pc=20 -> instr=8E080000.
REQ-040 SHALL cover reset: rst asserted mid-stream -> outputs drop to NOP/0 without waiting for a clock edge, and the previously loaded contents are read back intact after release.
